// File: rtl/gate_response_checker.sv
// Receive-side checker for two-input gate DUTs: compares each sampled y against the
// selected gate function, tracks input coverage, counts mismatches and reports pass/fail.
module gate_response_checker #(
   parameter int ERR_W   = 8,
   parameter int TIMEOUT = 64,
   parameter int TMR_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             vec_valid,
   input  logic             a,
   input  logic             b,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [3:0]       coverage,
   output logic [ERR_W-1:0] err_count,
   output logic             first_fail_valid,
   output logic [2:0]       first_fail
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e           state_q;
   logic [2:0]       op_q;
   logic [TMR_W-1:0] timer_q;
   logic [3:0]       cov_q;
   logic [ERR_W-1:0] err_q;
   logic             ffv_q;
   logic [2:0]       ff_q;
   logic             timeout_q, busy_q, done_q, pass_q;

   logic             exp_y, mis;
   logic [3:0]       cov_d;
   logic [ERR_W-1:0] err_d;
   logic             cmpl, tmo_end;

   always_comb begin
      exp_y = 1'b0;
      case (op_q)
         3'd0:    exp_y = a & b;
         3'd1:    exp_y = a | b;
         3'd2:    exp_y = ~(a & b);
         3'd3:    exp_y = ~(a | b);
         3'd4:    exp_y = a ^ b;
         3'd5:    exp_y = ~(a ^ b);
         default: exp_y = 1'b0;
      endcase
   end

   // Next-state values include the sample presented this cycle.
   assign mis     = vec_valid & (y != exp_y);
   assign cov_d   = cov_q | (vec_valid ? (4'b0001 << {a, b}) : 4'b0000);
   assign err_d   = (mis && (err_q != {ERR_W{1'b1}})) ? err_q + 1'b1 : err_q;
   assign cmpl    = (cov_d == 4'hF);
   assign tmo_end = (timer_q == TMR_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         timer_q   <= '0;
         cov_q     <= '0;
         err_q     <= '0;
         ffv_q     <= 1'b0;
         ff_q      <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q   <= S_RUN;
                  op_q      <= op;
                  timer_q   <= '0;
                  cov_q     <= '0;
                  err_q     <= '0;
                  ffv_q     <= 1'b0;
                  ff_q      <= '0;
                  timeout_q <= 1'b0;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  pass_q    <= 1'b0;
               end
            end
            S_RUN: begin
               timer_q <= timer_q + 1'b1;
               cov_q   <= cov_d;
               err_q   <= err_d;
               if (mis && !ffv_q) begin
                  ffv_q <= 1'b1;
                  ff_q  <= {a, b, y};
               end
               // Completion takes precedence over a timeout landing on the same cycle.
               if (cmpl) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == '0);
               end else if (tmo_end) begin
                  state_q   <= S_DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
                  pass_q    <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign timeout          = timeout_q;
   assign coverage         = cov_q;
   assign err_count        = err_q;
   assign first_fail_valid = ffv_q;
   assign first_fail       = ff_q;

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Self-checking response analyser for two-input logic-gate DUTs: samples each applied {a,b} vector and the DUT output y, and compares y against the selected gate function.
- Tracks coverage of all four input combinations, counts mismatches, captures the first failing vector, and reports pass/fail with a timeout.
- Sits on the receive side of a gate test harness, opposite the stimulus driver, so gate-level checks run in hardware.

Parameters:
- ERR_W, 8, width of the saturating mismatch counter.
- TIMEOUT, 64, RUN cycles allowed to reach full coverage; must be >= 4.
- TMR_W, 8, timer width; 2^TMR_W must be > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle pulse that begins a check run.
- op  input  3  gate under test, latched on an accepted start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved.
- vec_valid  input  1  a, b, y are valid this cycle.
- a  input  1  DUT input a as applied.
- b  input  1  DUT input b as applied.
- y  input  1  DUT output for {a,b}.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  high in DONE only if coverage==4'hF, err_count==0 and timeout==0.
- timeout  output  1  run ended without full coverage.
- coverage  output  4  bit {a,b} set once that combination has been sampled.
- err_count  output  ERR_W  number of mismatches, saturating.
- first_fail_valid  output  1  first_fail holds a captured vector.
- first_fail  output  3  {a,b,y} of the first mismatch.

Behaviour:
- Reset: synchronous. On an rst_n=0 edge the state goes to IDLE and every output goes to 0, including a reset taken mid-run. Reset has priority over all other inputs.
- All outputs are registered. A sample's effect is visible the cycle after it is presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: vec_valid is ignored. On start: latch op; clear coverage, err_count, first_fail_valid, first_fail, timeout and timer; go to RUN the next cycle.
- RUN: the first cycle in RUN is RUN cycle 1; the timer increments every RUN cycle. start is ignored.
- Each sample (a cycle with vec_valid=1):
  - set coverage[{a,b}];
  - compute expected = f(op,a,b); reserved op gives expected=0;
  - on y != expected: err_count increments, saturating at 2^ERR_W-1;
  - if first_fail_valid==0, capture first_fail={a,b,y} and set first_fail_valid=1;
  - repeated vectors are checked and counted again.
- RUN to DONE on completion: coverage including the current sample reaches 4'hF. done goes high the cycle after the completing sample.
- RUN to DONE on timeout: RUN cycle TIMEOUT ends with coverage still incomplete. Set timeout=1 together with done.
- Completion and timeout in the same cycle: completion wins and timeout stays 0. The sample in that cycle is still checked.
- DONE: vec_valid is ignored, all results hold, busy=0. start restarts exactly as from IDLE, with results cleared the next cycle. Reset returns to IDLE.
- pass is a registered function of the final values. It is 0 outside DONE.

Test Plan:
- op=1 (OR); samples 00/0, 01/1, 10/1, 11/1 on consecutive cycles -> done=1 one cycle after the 4th sample, pass=1, coverage=4'hF, err_count=0, first_fail_valid=0.
- op=1; samples 00/0, 01/0, 10/0, 11/1 -> err_count=2, first_fail=3'b010, pass=0, timeout=0.
- op=4 (XOR), TIMEOUT=16; samples 00, 01, 10 only, all correct -> done after RUN cycle 16, timeout=1, coverage=4'b0111, pass=0.
- ERR_W=2, op=0 (AND); sample 00 with y=1 five times, then 01/0, 10/0, 11/1 -> err_count saturates at 3, first_fail=3'b001.
- Coverage completes on RUN cycle TIMEOUT -> timeout=0, pass=1.
- start pulse during RUN -> ignored, counts unchanged. rst_n=0 mid-run -> all outputs 0 next cycle. start in DONE -> results cleared, busy=1 next cycle.
